// File: rtl/freq_meter_pkg.sv
// Shared constants for the panel measurement blocks: FSM encodings and the
// default window length for the 50 MHz board clock.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } meter_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
  localparam int unsigned DEF_CNT_W       = 27;
  localparam int unsigned DEF_GATE_W      = 26;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse, shared by panel
// blocks that take asynchronous button or sensor inputs.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);

  logic s0;
  logic s1;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= d_async;
      s1   <= s0;
      prev <= s1;
    end
  end

  assign q_sync = s1;
  assign rise   = s1 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of a slow asynchronous signal over a window of
// GATE_CYCLES clocks and reports the latched count with a valid pulse.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned GATE_W      = DEF_GATE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             start,
  input  logic             cont_mode,
  output logic             busy,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow
);

  meter_state_t      state_q;
  meter_state_t      state_d;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] gate_d;
  logic [CNT_W-1:0]  edge_q;
  logic [CNT_W-1:0]  edge_d;
  logic              sat_q;
  logic              sat_d;

  logic              sig_sync;
  logic              sig_rise;
  logic              sig_edge;
  logic              at_max_c;
  logic [CNT_W-1:0]  final_cnt_c;
  logic              final_sat_c;
  logic              term_c;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (sig),
    .q_sync  (sig_sync),
    .rise    (sig_rise)
  );

  // rise already implies the synced level is high; the AND keeps it explicit
  assign sig_edge = sig_rise & sig_sync;

  // Saturating count including an edge that lands in the current cycle
  assign at_max_c    = (edge_q == {CNT_W{1'b1}});
  assign final_cnt_c = edge_q + CNT_W'(sig_edge & ~at_max_c);
  assign final_sat_c = sat_q | (sig_edge & at_max_c);

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    term_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        edge_d = '0;
        sat_d  = 1'b0;
        if (start || cont_mode) begin
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        if (gate_q == GATE_W'(GATE_CYCLES - 1)) begin
          term_c = 1'b1;
          gate_d = '0;
          edge_d = '0;
          sat_d  = 1'b0;
          if (!cont_mode) begin
            state_d = ST_IDLE;
          end
        end else begin
          gate_d = gate_q + GATE_W'(1);
          edge_d = final_cnt_c;
          sat_d  = final_sat_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs; results hold until the next terminal cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q     <= '0;
      edge_q     <= '0;
      sat_q      <= 1'b0;
      busy       <= 1'b0;
      freq_valid <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      sat_q      <= sat_d;
      busy       <= (state_d == ST_GATE);
      freq_valid <= term_c;
      if (term_c) begin
        freq_out <= final_cnt_c;
        overflow <= final_sat_c;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle window; an 8-bit and a
// 5-bit counter instance share the same stimulus.
module tb_freq_meter;

  logic       clk;
  logic       rst;
  logic       sig;
  logic       start;
  logic       cont_mode;

  logic       busy;
  logic [7:0] freq_out;
  logic       freq_valid;
  logic       overflow;

  logic       busy5;
  logic [4:0] freq_out5;
  logic       freq_valid5;
  logic       overflow5;

  int         checks;
  int         errors;
  int         per;
  logic       lvl;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .GATE_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig),
    .start      (start),
    .cont_mode  (cont_mode),
    .busy       (busy),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .overflow   (overflow)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(5), .GATE_W(7)) dut5 (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig),
    .start      (start),
    .cont_mode  (cont_mode),
    .busy       (busy5),
    .freq_out   (freq_out5),
    .freq_valid (freq_valid5),
    .overflow   (overflow5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave of period per clocks, or a constant lvl when per == 0
  initial begin
    int ph;
    ph  = 0;
    sig = 1'b0;
    forever begin
      @(negedge clk);
      if (per == 0) begin
        sig = lvl;
      end else begin
        ph  = (ph + 1) % per;
        sig = (ph < per / 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!freq_valid && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   n;
    logic bz;
    logic seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    cont_mode = 1'b0;
    per       = 10;
    lvl       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(freq_valid), 32'd0);
    chk("rst_freq", 32'(freq_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single window, period 10
    pulse_start();
    chk("t1_busy_on", 32'(busy), 32'd1);
    count_busy(n);
    chk("t1_busy_len", 32'(n), 32'd100);
    chk("t1_valid", 32'(freq_valid), 32'd1);
    chk("t1_freq", 32'(freq_out), 32'd10);
    chk("t1_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    chk("t1_valid_one", 32'(freq_valid), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_freq_hold", 32'(freq_out), 32'd10);

    // Constant high, then constant low
    per = 0; lvl = 1'b1;
    repeat (10) @(negedge clk);
    pulse_start();
    count_busy(n);
    chk("t2_hi_valid", 32'(freq_valid), 32'd1);
    chk("t2_hi_freq", 32'(freq_out), 32'd0);
    chk("t2_hi_ovf", 32'(overflow), 32'd0);
    lvl = 1'b0;
    repeat (10) @(negedge clk);
    pulse_start();
    count_busy(n);
    chk("t2_lo_valid", 32'(freq_valid), 32'd1);
    chk("t2_lo_freq", 32'(freq_out), 32'd0);
    chk("t2_lo_ovf", 32'(overflow), 32'd0);

    // Period 2: 50 edges saturate the 5-bit counter
    per = 2;
    repeat (6) @(negedge clk);
    pulse_start();
    count_busy(n);
    chk("t3_valid5", 32'(freq_valid5), 32'd1);
    chk("t3_busy5", 32'(busy5), 32'd0);
    chk("t3_freq5", 32'(freq_out5), 32'd31);
    chk("t3_ovf5", 32'(overflow5), 32'd1);
    chk("t3_freq8", 32'(freq_out), 32'd50);
    chk("t3_ovf8", 32'(overflow), 32'd0);
    per = 10;
    repeat (12) @(negedge clk);
    pulse_start();
    count_busy(n);
    chk("t3_rec_freq5", 32'(freq_out5), 32'd10);
    chk("t3_rec_ovf5", 32'(overflow5), 32'd0);

    // Continuous mode, period 4
    per = 4;
    repeat (8) @(negedge clk);
    cont_mode = 1'b1;
    @(negedge clk);
    chk("t4_busy_on", 32'(busy), 32'd1);
    wait_valid(n);
    chk("t4_first_seen", 32'(freq_valid), 32'd1);
    chk("t4_first_freq", 32'(freq_out), 32'd25);
    for (int k = 0; k < 2; k++) begin
      bz = 1'b1;
      @(negedge clk);
      n = 1;
      while (!freq_valid && n < 300) begin
        bz &= busy;
        n++;
        @(negedge clk);
      end
      bz &= busy;
      chk("t4_spacing", 32'(n), 32'd100);
      chk("t4_freq", 32'(freq_out), 32'd25);
      chk("t4_busy_held", 32'(bz), 32'd1);
    end
    repeat (40) @(negedge clk);
    cont_mode = 1'b0;
    wait_valid(n);
    chk("t4_last_delay", 32'(n), 32'd60);
    chk("t4_last_freq", 32'(freq_out), 32'd25);
    chk("t4_last_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_idle_valid", 32'(freq_valid), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // Reset mid-window aborts without a result
    per = 10;
    pulse_start();
    repeat (49) @(negedge clk);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_freq", 32'(freq_out), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    chk("t5_rst_valid", 32'(freq_valid), 32'd0);
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (freq_valid) seen = 1'b1;
    end
    chk("t5_no_valid", 32'(seen), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // Start during GATE is ignored and not queued
    pulse_start();
    n = 0;
    while (busy && n < 300) begin
      n++;
      start = (n == 30);
      @(negedge clk);
    end
    start = 1'b0;
    chk("t5_ign_len", 32'(n), 32'd100);
    chk("t5_ign_valid", 32'(freq_valid), 32'd1);
    chk("t5_ign_freq", 32'(freq_out), 32'd10);
    @(negedge clk);
    chk("t5_no_queue", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
